// File: rtl/freq_load_arbiter.sv
// Round-robin arbiter sharing one frequency register between note sources.
// Drives FREQ_OUT/LOAD, skips duplicate words, and holds a settle window.
module freq_load_arbiter #(
  parameter int NUM_REQ       = 4,
  parameter int FREQ_W        = 20,
  parameter int SETTLE_CYCLES = 4,
  parameter int ID_W          = 2
) (
  input  logic                      clk,
  input  logic                      rst_n,
  input  logic [NUM_REQ-1:0]        REQ,
  input  logic [NUM_REQ*FREQ_W-1:0] REQ_FREQ,
  output logic [NUM_REQ-1:0]        ACK,
  output logic [FREQ_W-1:0]         FREQ_OUT,
  output logic                      LOAD,
  output logic                      BUSY,
  output logic [ID_W-1:0]           GRANT_ID
);

  localparam logic [1:0] S_IDLE   = 2'd0;
  localparam logic [1:0] S_LOAD   = 2'd1;
  localparam logic [1:0] S_SETTLE = 2'd2;

  localparam logic [ID_W:0] NR = (ID_W+1)'(NUM_REQ);
  localparam logic [7:0] SETTLE_INIT =
    8'(SETTLE_CYCLES > 0 ? SETTLE_CYCLES - 1 : 0);

  logic [1:0]         state_q, state_d;
  logic [ID_W-1:0]    ptr_q, ptr_d;
  logic [7:0]         cnt_q, cnt_d;
  logic [FREQ_W-1:0]  freq_q, freq_d;
  logic               load_q, load_d;
  logic               busy_q, busy_d;
  logic [NUM_REQ-1:0] ack_q, ack_d;
  logic [ID_W-1:0]    gid_q, gid_d;

  logic [NUM_REQ-1:0] req_rot;
  logic [NUM_REQ-1:0] gnt_oh;
  logic               found;
  logic [ID_W:0]      off;
  logic [ID_W:0]      sum;
  logic [ID_W:0]      nxt;
  logic [ID_W-1:0]    gnt;
  logic [FREQ_W-1:0]  word;

  // Rotate so bit 0 is the pointer; lowest set bit wins.
  always_comb begin
    req_rot = NUM_REQ'({REQ, REQ} >> ptr_q);
    found   = 1'b0;
    off     = '0;
    for (int i = NUM_REQ - 1; i >= 0; i--) begin
      if (req_rot[i]) begin
        found = 1'b1;
        off   = (ID_W+1)'(i);
      end
    end
    sum = {1'b0, ptr_q} + off;
    if (sum >= NR) sum = sum - NR;
    gnt = sum[ID_W-1:0];
    nxt = {1'b0, gnt} + (ID_W+1)'(1);
    if (nxt == NR) nxt = '0;
    word   = '0;
    gnt_oh = '0;
    for (int i = 0; i < NUM_REQ; i++) begin
      if (gnt == ID_W'(i)) begin
        word      = REQ_FREQ[i*FREQ_W +: FREQ_W];
        gnt_oh[i] = found;
      end
    end
  end

  always_comb begin
    state_d = state_q;
    ptr_d   = ptr_q;
    cnt_d   = cnt_q;
    freq_d  = freq_q;
    load_d  = 1'b0;
    ack_d   = '0;
    busy_d  = busy_q;
    gid_d   = gid_q;
    case (state_q)
      S_IDLE: begin
        if (found) begin
          ack_d = gnt_oh;
          gid_d = gnt;
          ptr_d = nxt[ID_W-1:0];
          if (word != freq_q) begin
            freq_d  = word;
            load_d  = 1'b1;
            busy_d  = 1'b1;
            state_d = S_LOAD;
          end
        end
      end
      S_LOAD: begin
        if (SETTLE_CYCLES == 0) begin
          busy_d  = 1'b0;
          state_d = S_IDLE;
        end else begin
          cnt_d   = SETTLE_INIT;
          state_d = S_SETTLE;
        end
      end
      S_SETTLE: begin
        if (cnt_q == 8'd0) begin
          busy_d  = 1'b0;
          state_d = S_IDLE;
        end else begin
          cnt_d = cnt_q - 8'd1;
        end
      end
      default: begin
        busy_d  = 1'b0;
        state_d = S_IDLE;
      end
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= S_IDLE;
      ptr_q   <= '0;
      cnt_q   <= '0;
      freq_q  <= '0;
      load_q  <= 1'b0;
      busy_q  <= 1'b0;
      ack_q   <= '0;
      gid_q   <= '0;
    end else begin
      state_q <= state_d;
      ptr_q   <= ptr_d;
      cnt_q   <= cnt_d;
      freq_q  <= freq_d;
      load_q  <= load_d;
      busy_q  <= busy_d;
      ack_q   <= ack_d;
      gid_q   <= gid_d;
    end
  end

  assign ACK      = ack_q;
  assign FREQ_OUT = freq_q;
  assign LOAD     = load_q;
  assign BUSY     = busy_q;
  assign GRANT_ID = gid_q;

endmodule

// File: tb/tb_freq_load_arbiter.sv
// Directed and randomised bench for freq_load_arbiter.
// Inputs driven and outputs sampled on the falling edge.
module tb_freq_load_arbiter;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic [3:0]  REQ = '0;
  logic [19:0] w [4];
  logic [79:0] REQ_FREQ;
  logic [3:0]  ACK;
  logic [19:0] FREQ_OUT;
  logic        LOAD;
  logic        BUSY;
  logic [1:0]  GRANT_ID;

  int tests = 0;
  int fails = 0;

  assign REQ_FREQ = {w[3], w[2], w[1], w[0]};

  always #5 clk = ~clk;

  freq_load_arbiter #(
    .NUM_REQ(4), .FREQ_W(20), .SETTLE_CYCLES(4), .ID_W(2)
  ) dut (
    .clk(clk), .rst_n(rst_n), .REQ(REQ), .REQ_FREQ(REQ_FREQ),
    .ACK(ACK), .FREQ_OUT(FREQ_OUT), .LOAD(LOAD), .BUSY(BUSY),
    .GRANT_ID(GRANT_ID)
  );

  task automatic test_reset;
    rst_n = 1'b0;
    REQ = '0;
    repeat (3) @(negedge clk);
    tests++; if (FREQ_OUT !== 20'd0) begin fails++;
      $display("FAIL rst_freq: got %0d want 0", FREQ_OUT); end
    tests++; if (LOAD !== 1'b0) begin fails++;
      $display("FAIL rst_load: got %b want 0", LOAD); end
    tests++; if (ACK !== 4'b0) begin fails++;
      $display("FAIL rst_ack: got %b want 0000", ACK); end
    tests++; if (BUSY !== 1'b0) begin fails++;
      $display("FAIL rst_busy: got %b want 0", BUSY); end
    tests++; if (GRANT_ID !== 2'd0) begin fails++;
      $display("FAIL rst_gid: got %0d want 0", GRANT_ID); end
    rst_n = 1'b1;
  endtask

  task automatic test_single_load;
    int n;
    w[0] = 20'd79021;
    REQ = 4'b0001;
    @(negedge clk);
    tests++; if (LOAD !== 1'b1) begin fails++;
      $display("FAIL single_load: got %b want 1", LOAD); end
    tests++; if (ACK !== 4'b0001) begin fails++;
      $display("FAIL single_ack: got %b want 0001", ACK); end
    tests++; if (FREQ_OUT !== 20'd79021) begin fails++;
      $display("FAIL single_freq: got %0d want 79021", FREQ_OUT); end
    tests++; if (BUSY !== 1'b1) begin fails++;
      $display("FAIL single_busy: got %b want 1", BUSY); end
    REQ = '0;
    n = 0;
    for (int i = 0; i < 20 && BUSY; i++) begin
      n++;
      @(negedge clk);
    end
    tests++; if (n != 5) begin fails++;
      $display("FAIL single_busy_len: got %0d want 5", n); end
  endtask

  task automatic test_round_robin;
    int ids [5];
    int cyc [5];
    logic [19:0] fr [5];
    int n;
    int exp_id;
    logic [19:0] exp_w;
    rst_n = 1'b0;
    @(negedge clk);
    rst_n = 1'b1;
    w[0] = 20'd100; w[1] = 20'd200; w[2] = 20'd300; w[3] = 20'd400;
    REQ = 4'b1111;
    n = 0;
    for (int c = 0; c < 40 && n < 5; c++) begin
      @(negedge clk);
      if (LOAD) begin
        ids[n] = int'(GRANT_ID);
        fr[n]  = FREQ_OUT;
        cyc[n] = c;
        n++;
      end
    end
    REQ = '0;
    tests++; if (n != 5) begin fails++;
      $display("FAIL rr_count: got %0d want 5", n); end
    for (int k = 0; k < n; k++) begin
      exp_id = k % 4;
      exp_w  = 20'((exp_id + 1) * 100);
      tests++; if (ids[k] != exp_id) begin fails++;
        $display("FAIL rr_id%0d: got %0d want %0d", k, ids[k], exp_id); end
      tests++; if (fr[k] !== exp_w) begin fails++;
        $display("FAIL rr_freq%0d: got %0d want %0d", k, fr[k], exp_w); end
      if (k > 0) begin
        tests++; if (cyc[k] - cyc[k-1] != 6) begin fails++;
          $display("FAIL rr_gap%0d: got %0d want 6", k, cyc[k] - cyc[k-1]); end
      end
    end
    for (int i = 0; i < 20 && BUSY; i++) @(negedge clk);
    tests++; if (BUSY !== 1'b0) begin fails++;
      $display("FAIL rr_idle: got %b want 0", BUSY); end
  endtask

  task automatic test_duplicate;
    w[1] = 20'd500;
    REQ = 4'b0010;
    @(negedge clk);
    REQ = '0;
    tests++; if (LOAD !== 1'b1 || FREQ_OUT !== 20'd500) begin fails++;
      $display("FAIL dup_setup: got load=%b freq=%0d want 1/500", LOAD, FREQ_OUT); end
    for (int i = 0; i < 20 && BUSY; i++) @(negedge clk);
    w[2] = 20'd500;
    REQ = 4'b0100;
    @(negedge clk);
    REQ = '0;
    tests++; if (ACK !== 4'b0100) begin fails++;
      $display("FAIL dup_ack: got %b want 0100", ACK); end
    tests++; if (LOAD !== 1'b0) begin fails++;
      $display("FAIL dup_load: got %b want 0", LOAD); end
    tests++; if (BUSY !== 1'b0) begin fails++;
      $display("FAIL dup_busy: got %b want 0", BUSY); end
    tests++; if (GRANT_ID !== 2'd2) begin fails++;
      $display("FAIL dup_gid: got %0d want 2", GRANT_ID); end
    @(negedge clk);
    tests++; if (ACK !== 4'b0000 || LOAD !== 1'b0) begin fails++;
      $display("FAIL dup_after: got ack=%b load=%b want 0000/0", ACK, LOAD); end
    tests++; if (FREQ_OUT !== 20'd500) begin fails++;
      $display("FAIL dup_freq: got %0d want 500", FREQ_OUT); end
  endtask

  task automatic test_settle_hold;
    int bad;
    w[1] = 20'd777;
    REQ = 4'b0010;
    @(negedge clk);
    REQ = '0;
    tests++; if (LOAD !== 1'b1 || FREQ_OUT !== 20'd777) begin fails++;
      $display("FAIL hold_load: got load=%b freq=%0d want 1/777", LOAD, FREQ_OUT); end
    @(negedge clk);
    w[1] = 20'd0;
    REQ = 4'b0010;
    bad = 0;
    for (int i = 0; i < 20 && BUSY; i++) begin
      if (FREQ_OUT !== 20'd777 || LOAD !== 1'b0) bad++;
      @(negedge clk);
    end
    tests++; if (bad != 0) begin fails++;
      $display("FAIL hold_settle: got %0d bad cycles want 0", bad); end
    tests++; if (BUSY !== 1'b0 || FREQ_OUT !== 20'd777) begin fails++;
      $display("FAIL hold_end: got busy=%b freq=%0d want 0/777", BUSY, FREQ_OUT); end
    @(negedge clk);
    REQ = '0;
    tests++; if (LOAD !== 1'b1 || FREQ_OUT !== 20'd0 || GRANT_ID !== 2'd1) begin
      fails++;
      $display("FAIL hold_next: got load=%b freq=%0d gid=%0d want 1/0/1",
               LOAD, FREQ_OUT, GRANT_ID);
    end
    for (int i = 0; i < 20 && BUSY; i++) @(negedge clk);
    tests++; if (BUSY !== 1'b0) begin fails++;
      $display("FAIL hold_idle: got %b want 0", BUSY); end
  endtask

  task automatic test_reset_mid_settle;
    w[2] = 20'd1234;
    REQ = 4'b0100;
    @(negedge clk);
    REQ = '0;
    tests++; if (LOAD !== 1'b1) begin fails++;
      $display("FAIL mid_load: got %b want 1", LOAD); end
    repeat (2) @(negedge clk);
    tests++; if (BUSY !== 1'b1) begin fails++;
      $display("FAIL mid_busy: got %b want 1", BUSY); end
    rst_n = 1'b0;
    #1;
    tests++; if (FREQ_OUT !== 20'd0 || LOAD !== 1'b0 || ACK !== 4'b0 ||
                 BUSY !== 1'b0 || GRANT_ID !== 2'd0) begin
      fails++;
      $display("FAIL mid_clear: got freq=%0d load=%b ack=%b busy=%b gid=%0d want 0",
               FREQ_OUT, LOAD, ACK, BUSY, GRANT_ID);
    end
    @(negedge clk);
    rst_n = 1'b1;
    w[1] = 20'd11;
    w[3] = 20'd33;
    REQ = 4'b1010;
    @(negedge clk);
    REQ = 4'b1000;
    tests++; if (GRANT_ID !== 2'd1 || ACK !== 4'b0010 || FREQ_OUT !== 20'd11) begin
      fails++;
      $display("FAIL mid_first: got gid=%0d ack=%b freq=%0d want 1/0010/11",
               GRANT_ID, ACK, FREQ_OUT);
    end
    REQ = '0;
    for (int i = 0; i < 20 && BUSY; i++) @(negedge clk);
    tests++; if (BUSY !== 1'b0) begin fails++;
      $display("FAIL mid_idle: got %b want 0", BUSY); end
  endtask

  task automatic test_random;
    int last;
    bit seen;
    logic [19:0] prev;
    seen = 1'b0;
    last = 0;
    prev = FREQ_OUT;
    for (int c = 0; c < 500; c++) begin
      @(negedge clk);
      tests++; if ($countones(ACK) > 1) begin fails++;
        $display("FAIL rnd_onehot: got ack=%b at %0d", ACK, c); end
      if (LOAD) begin
        tests++; if ($countones(ACK) != 1) begin fails++;
          $display("FAIL rnd_load_ack: got ack=%b want one bit at %0d", ACK, c); end
        if (seen) begin
          tests++; if (c - last < 6) begin fails++;
            $display("FAIL rnd_gap: got %0d want >=6 at %0d", c - last, c); end
        end
        seen = 1'b1;
        last = c;
      end else begin
        tests++; if (FREQ_OUT !== prev) begin fails++;
          $display("FAIL rnd_stable: got %0d want %0d at %0d", FREQ_OUT, prev, c); end
      end
      for (int i = 0; i < 4; i++) begin
        if (ACK[i]) begin
          tests++; if (FREQ_OUT !== w[i]) begin fails++;
            $display("FAIL rnd_word%0d: got %0d want %0d at %0d",
                     i, FREQ_OUT, w[i], c);
          end
        end
      end
      prev = FREQ_OUT;
      for (int i = 0; i < 4; i++) begin
        if (ACK[i]) begin
          REQ[i] = 1'b0;
        end else if (!REQ[i] && $urandom_range(0, 2) == 0) begin
          w[i] = 20'($urandom_range(0, 3));
          REQ[i] = 1'b1;
        end
      end
    end
    REQ = '0;
    for (int i = 0; i < 20 && BUSY; i++) @(negedge clk);
    tests++; if (BUSY !== 1'b0) begin fails++;
      $display("FAIL rnd_idle: got %b want 0", BUSY); end
  endtask

  initial begin
    for (int i = 0; i < 4; i++) w[i] = '0;
    test_reset;
    test_single_load;
    test_round_robin;
    test_duplicate;
    test_settle_hold;
    test_reset_mid_settle;
    test_random;
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
